bullcow_match_ctrl: RTL and testbench



---
 rtl/bullcow_pkg.sv | 27 ++
 rtl/bullcow_turn_timer.sv | 18 +
 rtl/bullcow_match_ctrl.sv | 123 ++++++++++++
 tb/tb_bullcow_match_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullcow_pkg.sv
// bullcow_pkg: shared state encoding, code/score types and digit validation for the Bulls & Cows match controller
package bullcow_pkg;
  localparam int DIGITS = 4;
  localparam int DIGIT_W = 4;
  typedef enum logic [2:0] {
    J1_SETUP  = 3'b000,
    J2_SETUP  = 3'b001,
    J1_GUESS  = 3'b010,
    J2_GUESS  = 3'b011,
    SCORE     = 3'b100,
    MATCH_END = 3'b110,
    ROUND_END = 3'b111
  } state_t;
  typedef logic [DIGITS*DIGIT_W-1:0] code_t;
  typedef logic [2:0] count_t;
  function automatic logic digits_distinct(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      for (int j = i + 1; j < DIGITS; j++)
        if (v[i*DIGIT_W +: DIGIT_W] == v[j*DIGIT_W +: DIGIT_W]) ok = 1'b0;
    return ok;
  endfunction
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v == 8'hFF ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/bullcow_turn_timer.sv
// bullcow_turn_timer: counts cycles in a guess turn and flags expiry on the TURN_TIMEOUT-th cycle
module bullcow_turn_timer #(
  parameter int TURN_TIMEOUT = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(TURN_TIMEOUT);
  logic [W-1:0] cnt;
  assign expire = enable && cnt == W'(TURN_TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else if (enable && !expire) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/bullcow_match_ctrl.sv
// bullcow_match_ctrl: Bulls & Cows match sequencer with turn timer, guess limit and scoring handshake
module bullcow_match_ctrl
  import bullcow_pkg::*;
#(
  parameter int TURN_TIMEOUT = 1000,
  parameter int MAX_GUESSES  = 10,
  parameter int WIN_POINTS   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enter,
  input  code_t      SW,
  output logic       cmp_req,
  output code_t      cmp_secret,
  output code_t      cmp_guess,
  input  logic       cmp_ack,
  input  count_t     cmp_bulls,
  input  count_t     cmp_cows,
  output count_t     bull_count,
  output count_t     cow_count,
  output logic [2:0] game_state,
  output logic       active_player,
  output logic       invalid,
  output logic       timeout,
  output logic [7:0] J1_points,
  output logic [7:0] J2_points,
  output logic       match_over
);
  localparam int GW = $clog2(MAX_GUESSES + 1);
  localparam logic [GW-1:0] G_MAX = GW'(MAX_GUESSES);
  state_t state, next;
  code_t secret1, secret2;
  logic enter_q, press, valid, setup, guessing, expire, take, forfeit, win, parity, turn;
  logic draw_score, draw_forfeit, points_done;
  logic [GW-1:0] used1, used2, used_me, used_other, used_inc;
  assign press = enter && !enter_q;
  assign valid = digits_distinct(SW);
  assign setup = state == J1_SETUP || state == J2_SETUP;
  assign guessing = state == J1_GUESS || state == J2_GUESS;
  assign take = guessing && press && valid;
  assign forfeit = expire && !take;
  assign win = cmp_ack && cmp_bulls == 3'd4;
  assign used_me = state[0] ? used2 : used1;
  assign used_other = state[0] ? used1 : used2;
  assign used_inc = used_me == G_MAX ? used_me : used_me + 1'b1;
  assign draw_score = used1 == G_MAX && used2 == G_MAX;
  assign draw_forfeit = used_inc == G_MAX && used_other == G_MAX;
  assign points_done = J1_points >= 8'(WIN_POINTS) || J2_points >= 8'(WIN_POINTS);
  assign game_state = state;
  assign active_player = state[2] ? turn : state[0];
  assign cmp_req = state == SCORE;
  assign cmp_secret = cmp_req ? (turn ? secret1 : secret2) : '0;
  assign invalid = !reset && press && !valid && (setup || (guessing && !expire));
  assign timeout = forfeit;
  assign match_over = state == MATCH_END;
  bullcow_turn_timer #(.TURN_TIMEOUT(TURN_TIMEOUT)) timer (
    .clock (clock),
    .reset (reset),
    .clear (next != state),
    .enable(guessing),
    .expire(expire)
  );
  always_comb begin
    next = state;
    case (state)
      J1_SETUP:           next = press && valid ? J2_SETUP : state;
      J2_SETUP:           next = press && valid ? (parity ? J2_GUESS : J1_GUESS) : state;
      J1_GUESS, J2_GUESS: next = take ? SCORE : !forfeit ? state : draw_forfeit ? ROUND_END : state[0] ? J1_GUESS : J2_GUESS;
      SCORE:              next = !cmp_ack ? state : (win || draw_score) ? ROUND_END : turn ? J1_GUESS : J2_GUESS;
      ROUND_END:          next = !press ? state : points_done ? MATCH_END : J1_SETUP;
      MATCH_END:          next = press ? J1_SETUP : state;
      default:            next = J1_SETUP;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= J1_SETUP;
      enter_q <= 1'b0;
      secret1 <= '0;
      secret2 <= '0;
      cmp_guess <= '0;
      used1 <= '0;
      used2 <= '0;
      bull_count <= '0;
      cow_count <= '0;
      J1_points <= '0;
      J2_points <= '0;
      parity <= 1'b0;
      turn <= 1'b0;
    end else begin
      state <= next;
      enter_q <= enter;
      if (state == J1_SETUP && press && valid) secret1 <= SW;
      if (state == J2_SETUP && press && valid) secret2 <= SW;
      if (take) cmp_guess <= SW;
      if (take || forfeit) begin
        turn <= state[0];
        if (state[0]) used2 <= used_inc;
        else used1 <= used_inc;
      end
      if (cmp_req && cmp_ack) begin
        bull_count <= cmp_bulls;
        cow_count <= cmp_cows;
        if (win && turn) J2_points <= sat_inc(J2_points);
        if (win && !turn) J1_points <= sat_inc(J1_points);
      end
      if (state == ROUND_END && press) begin
        used1 <= '0;
        used2 <= '0;
        secret1 <= '0;
        secret2 <= '0;
        bull_count <= '0;
        cow_count <= '0;
        parity <= !parity;
      end
      if (state == MATCH_END && press) begin
        J1_points <= '0;
        J2_points <= '0;
        parity <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bullcow_match_ctrl.sv
// tb_bullcow_match_ctrl: directed match scenarios checked every cycle against a rules-level game model
module tb_bullcow_match_ctrl;
  localparam int TT = 8, MG = 2, WP = 2;
  localparam logic [2:0] S1 = 3'b000, S2 = 3'b001, G1 = 3'b010, G2 = 3'b011, SC = 3'b100, ME = 3'b110, RE = 3'b111;
  logic clk = 1'b0, reset = 1'b1, enter = 1'b0, cmp_ack = 1'b0;
  logic [15:0] SW = 16'h0;
  logic [2:0] cmp_bulls = 3'd0, cmp_cows = 3'd0;
  logic cmp_req, active_player, invalid, timeout, match_over;
  logic [15:0] cmp_secret, cmp_guess;
  logic [2:0] bull_count, cow_count, game_state;
  logic [7:0] J1_points, J2_points;
  int n_cmp = 0, n_bad = 0, req_age = 0, ack_delay = 3;
  bit checking = 0, late_ack = 0;

  bullcow_match_ctrl #(.TURN_TIMEOUT(TT), .MAX_GUESSES(MG), .WIN_POINTS(WP)) dut (
    .clock(clk), .reset(reset), .enter(enter), .SW(SW),
    .cmp_req(cmp_req), .cmp_secret(cmp_secret), .cmp_guess(cmp_guess),
    .cmp_ack(cmp_ack), .cmp_bulls(cmp_bulls), .cmp_cows(cmp_cows),
    .bull_count(bull_count), .cow_count(cow_count), .game_state(game_state),
    .active_player(active_player), .invalid(invalid), .timeout(timeout),
    .J1_points(J1_points), .J2_points(J2_points), .match_over(match_over)
  );

  always #5 clk = ~clk;

  function automatic bit distinct(input logic [15:0] v);
    int seen [16];
    foreach (seen[k]) seen[k] = 0;
    for (int k = 0; k < 4; k++) seen[v[4*k +: 4]]++;
    foreach (seen[k]) if (seen[k] > 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void score(input logic [15:0] s, input logic [15:0] g, output logic [2:0] b, output logic [2:0] c);
    b = 3'd0;
    c = 3'd0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (s[4*i +: 4] == g[4*j +: 4]) begin
          if (i == j) b++;
          else c++;
        end
  endfunction

  logic [2:0] m_st = S1, m_bulls = 3'd0, m_cows = 3'd0;
  logic m_prev = 1'b0, m_who = 1'b0;
  logic [15:0] m_sec [2];
  logic [15:0] m_guess = 16'h0;
  int m_used [2];
  int m_pts [2];
  int m_round = 1, m_cyc = 0;
  logic e_press, e_valid, e_setup, e_guessing, e_expire, e_invalid, e_timeout;

  always_comb begin
    e_press = enter && !m_prev;
    e_valid = distinct(SW);
    e_setup = m_st == S1 || m_st == S2;
    e_guessing = m_st == G1 || m_st == G2;
    e_expire = e_guessing && m_cyc == TT;
    e_invalid = !reset && e_press && !e_valid && (e_setup || (e_guessing && !e_expire));
    e_timeout = e_expire && !(e_press && e_valid);
  end

  task automatic start_turn(input logic p);
    m_st = p ? G2 : G1;
    m_cyc = 1;
  endtask

  always @(posedge clk) begin
    bit pr, ok, ex;
    logic p;
    pr = e_press;
    ok = e_valid;
    ex = e_expire;
    p = m_st == G2;
    if (reset) begin
      m_st = S1; m_prev = 1'b0; m_who = 1'b0; m_guess = 16'h0;
      m_sec[0] = 16'h0; m_sec[1] = 16'h0; m_used[0] = 0; m_used[1] = 0;
      m_pts[0] = 0; m_pts[1] = 0; m_round = 1; m_cyc = 0; m_bulls = 3'd0; m_cows = 3'd0;
    end else begin
      m_prev = enter;
      case (m_st)
        S1: if (pr && ok) begin m_sec[0] = SW; m_st = S2; end
        S2: if (pr && ok) begin m_sec[1] = SW; start_turn(m_round % 2 == 1 ? 1'b0 : 1'b1); end
        G1, G2: begin
          if ((pr && ok) || ex) begin
            m_who = p;
            if (m_used[p] < MG) m_used[p]++;
            if (pr && ok) begin m_guess = SW; m_st = SC; end
            else if (m_used[0] == MG && m_used[1] == MG) m_st = RE;
            else start_turn(!p);
          end else m_cyc++;
        end
        SC: if (cmp_ack) begin
          m_bulls = cmp_bulls;
          m_cows = cmp_cows;
          if (cmp_bulls == 3'd4) begin
            if (m_pts[m_who] < 255) m_pts[m_who]++;
            m_st = RE;
          end else if (m_used[0] == MG && m_used[1] == MG) m_st = RE;
          else start_turn(!m_who);
        end
        RE: if (pr) begin
          m_st = (m_pts[0] >= WP || m_pts[1] >= WP) ? ME : S1;
          m_used[0] = 0; m_used[1] = 0; m_sec[0] = 16'h0; m_sec[1] = 16'h0;
          m_bulls = 3'd0; m_cows = 3'd0; m_round++;
        end
        ME: if (pr) begin m_pts[0] = 0; m_pts[1] = 0; m_round = 1; m_st = S1; end
        default: m_st = S1;
      endcase
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [2:0] b, c;
    @(posedge clk);
    #1;
    cmp_ack = 1'b0;
    if (late_ack) begin
      cmp_bulls = 3'd4; cmp_cows = 3'd0; cmp_ack = 1'b1; late_ack = 0;
    end else if (cmp_req) begin
      req_age++;
      if (req_age == ack_delay) begin
        score(cmp_secret, cmp_guess, b, c);
        cmp_bulls = b; cmp_cows = c; cmp_ack = 1'b1;
      end
    end else req_age = 0;
  endtask

  task automatic press(input logic [15:0] code);
    SW = code; enter = 1'b1; tick();
    enter = 1'b0; tick();
  endtask

  task automatic wait_scored();
    int n;
    n = 0;
    while (game_state == SC && n < 20) begin tick(); n++; end
    chk("ack_wait", 16'(game_state == SC), 16'h0);
  endtask

  task automatic guess(input logic [15:0] code);
    press(code);
    wait_scored();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (checking) begin
          chk("state", 16'(game_state), 16'(m_st));
          chk("active", 16'(active_player), 16'(m_st == S1 ? 1'b0 : m_st == S2 ? 1'b1 : m_st == G1 ? 1'b0 : m_st == G2 ? 1'b1 : m_who));
          chk("req", 16'(cmp_req), 16'(m_st == SC));
          chk("secret", cmp_secret, m_st == SC ? m_sec[!m_who] : 16'h0);
          chk("guess", cmp_guess, m_guess);
          chk("bulls", 16'(bull_count), 16'(m_bulls));
          chk("cows", 16'(cow_count), 16'(m_cows));
          chk("invalid", 16'(invalid), 16'(e_invalid));
          chk("timeout", 16'(timeout), 16'(e_timeout));
          chk("j1_pts", 16'(J1_points), 16'(m_pts[0]));
          chk("j2_pts", 16'(J2_points), 16'(m_pts[1]));
          chk("match_over", 16'(match_over), 16'(m_st == ME));
        end
      end
    join_none
    repeat (3) tick();
    reset = 1'b0;
    checking = 1;
    chk("rst_state", 16'(game_state), 16'h0);
    chk("rst_req", 16'(cmp_req), 16'h0);
    chk("rst_pts", 16'({J1_points, J2_points}), 16'h0);
    // round 1: J1 opens; hold enter to confirm a single press
    SW = 16'h1234; enter = 1'b1;
    repeat (4) tick();
    enter = 1'b0; tick();
    chk("lit_hold_state", 16'(game_state), 16'h1);
    SW = 16'h1123; enter = 1'b1; #1;
    chk("lit_invalid", 16'(invalid), 16'h1);
    tick(); enter = 1'b0; tick();
    chk("lit_stay_j2setup", 16'(game_state), 16'h1);
    press(16'h5678);
    chk("lit_j1_guess", 16'(game_state), 16'h2);
    chk("lit_active_j1", 16'(active_player), 16'h0);
    SW = 16'h5687; enter = 1'b1; tick();
    chk("lit_req_rise", 16'(cmp_req), 16'h1);
    chk("lit_secret", cmp_secret, 16'h5678);
    chk("lit_guess", cmp_guess, 16'h5687);
    enter = 1'b0; tick();
    wait_scored();
    chk("lit_bulls", 16'(bull_count), 16'h2);
    chk("lit_cows", 16'(cow_count), 16'h2);
    chk("lit_to_j2", 16'(game_state), 16'h3);
    guess(16'h1234);
    chk("lit_win_state", 16'(game_state), 16'h7);
    chk("lit_j2_pts", 16'(J2_points), 16'h1);
    press(16'h0000);
    chk("lit_round_exit", 16'(game_state), 16'h0);
    // round 2: J2 opens; both players time out, second with an invalid press on the expiry cycle
    press(16'h0123);
    SW = 16'h4567; enter = 1'b1; tick();
    chk("lit_j2_first", 16'(game_state), 16'h3);
    enter = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("lit_timeout_cycle", 16'(timeout), 16'(i == 8));
      tick();
    end
    chk("lit_after_timeout", 16'(game_state), 16'h2);
    repeat (7) tick();
    SW = 16'h1123; enter = 1'b1; #1;
    chk("lit_collide_invalid", 16'(invalid), 16'h0);
    chk("lit_collide_timeout", 16'(timeout), 16'h1);
    tick();
    chk("lit_collide_state", 16'(game_state), 16'h3);
    enter = 1'b0; tick();
    guess(16'h0132);
    guess(16'h4567);
    chk("lit_j1_pts", 16'(J1_points), 16'h1);
    press(16'h0000);
    // round 3: every guess misses, the fourth ack ends the round as a draw
    press(16'h9876);
    press(16'h1234);
    guess(16'h4321);
    guess(16'h6789);
    guess(16'h1243);
    chk("lit_no_early_draw", 16'(game_state), 16'h3);
    guess(16'h9867);
    chk("lit_draw_state", 16'(game_state), 16'h7);
    chk("lit_draw_pts", 16'({J1_points, J2_points}), 16'h0101);
    press(16'h0000);
    // round 4: J1 reaches the winning total
    press(16'hABCD);
    press(16'h0F12);
    guess(16'h1234);
    guess(16'h0F12);
    press(16'h0000);
    chk("lit_match_end", 16'(game_state), 16'h6);
    chk("lit_match_over", 16'(match_over), 16'h1);
    press(16'h0000);
    chk("lit_match_clear", 16'({J1_points, J2_points}), 16'h0);
    chk("lit_match_restart", 16'(game_state), 16'h0);
    // round 5: reset while the scorer is still busy, then a stray ack
    press(16'h1234);
    press(16'h5678);
    ack_delay = 100;
    SW = 16'h5687; enter = 1'b1; tick();
    chk("lit_req_before_rst", 16'(cmp_req), 16'h1);
    enter = 1'b0; tick();
    reset = 1'b1; tick();
    chk("lit_rst_req", 16'(cmp_req), 16'h0);
    chk("lit_rst_score_state", 16'(game_state), 16'h0);
    reset = 1'b0; ack_delay = 3; late_ack = 1; tick(); tick();
    chk("lit_late_ack_state", 16'(game_state), 16'h0);
    chk("lit_late_ack_bulls", 16'(bull_count), 16'h0);
    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
